// File: rtl/handshake_fifo.sv
// Valid/ready elastic buffer: circular FIFO with occupancy count and
// first-word-fall-through output that reads as zero while empty.
module handshake_fifo #(
   parameter int wd    = 4,
   parameter int depth = 4,
   parameter int aw    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [wd-1:0] up_data,
   output logic          dn_valid,
   input  logic          dn_ready,
   output logic [wd-1:0] dn_data,
   output logic [aw:0]   count
);

   localparam logic [aw:0] full_cnt = (aw + 1)'(depth);

   logic [wd-1:0] mem [depth];
   logic [aw-1:0] wr_ptr;
   logic [aw-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // up_ready carries rst so a push can never land during reset, and a pop
   // on a full FIFO does not open the input in the same cycle.
   assign up_ready = rst & (count != full_cnt);
   assign dn_valid = (count != '0);
   assign dn_data  = dn_valid ? mem[rd_ptr] : '0;
   assign push     = up_valid & up_ready;
   assign pop      = dn_valid & dn_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately not reset; stale words are masked by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= up_data;
   end

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed plus randomized bench for handshake_fifo, checked against a
// queue-based model of the buffer's contents.
module tb_handshake_fifo;
   localparam int WD    = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          up_valid;
   logic          up_ready;
   logic [WD-1:0] up_data;
   logic          dn_valid;
   logic          dn_ready;
   logic [WD-1:0] dn_data;
   logic [AW:0]   count;

   int total = 0;
   int bad   = 0;
   logic [WD-1:0] q[$];

   handshake_fifo #(.wd(WD), .depth(DEPTH), .aw(AW)) dut (
      .clk(clk), .rst(rst),
      .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
      .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [31:0] exp_data;
      exp_data = (q.size() > 0) ? 32'(q[0]) : 32'd0;
      chk("count", 32'(count), 32'(q.size()));
      chk("dn_valid", 32'(dn_valid), 32'(q.size() > 0));
      chk("dn_data", 32'(dn_data), exp_data);
      chk("up_ready", 32'(up_ready), 32'(rst && q.size() < DEPTH));
   endtask

   // One clock edge: decide the transfers from the pre-edge view of the
   // model, then apply them and compare just after the edge.
   task automatic step();
      bit do_push;
      bit do_pop;
      do_push = up_valid && rst && (q.size() < DEPTH);
      do_pop  = rst && (q.size() > 0) && dn_ready;
      @(posedge clk);
      #1;
      if (!rst) q.delete();
      else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(up_data);
      end
      check_outputs();
   endtask

   task automatic push_word(input logic [WD-1:0] d);
      up_valid = 1'b1; up_data = d; dn_ready = 1'b0;
      step();
      up_valid = 1'b0;
   endtask

   task automatic pop_expect(input logic [WD-1:0] d);
      chk("order", 32'(dn_data), 32'(d));
      up_valid = 1'b0; dn_ready = 1'b1;
      step();
      dn_ready = 1'b0;
   endtask

   initial begin
      logic [WD-1:0] exp_seq [4];
      bit            pending;
      exp_seq = '{4'd8, 4'd12, 4'd9, 4'd3};

      // reset with up_valid held high
      rst = 1'b0; up_valid = 1'b1; up_data = 4'd5; dn_ready = 1'b0;
      @(negedge clk);
      step();
      step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_up_ready", 32'(up_ready), 32'd0);
      up_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rel_up_ready", 32'(up_ready), 32'd1);

      // single word
      push_word(4'd8);
      chk("single_data", 32'(dn_data), 32'd8);
      chk("single_count", 32'(count), 32'd1);
      dn_ready = 1'b1;
      step();
      dn_ready = 1'b0;
      chk("single_drain", 32'(dn_valid), 32'd0);
      chk("single_zero", 32'(dn_data), 32'd0);

      // fill, blocked push, drain in order, wrap
      for (int i = 0; i < 4; i++) push_word(exp_seq[i]);
      chk("full_count", 32'(count), 32'd4);
      chk("full_ready", 32'(up_ready), 32'd0);
      up_valid = 1'b1; up_data = 4'd5;
      step();
      step();
      up_valid = 1'b0;
      chk("blocked_count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) pop_expect(exp_seq[i]);
      push_word(4'd5);
      push_word(4'd7);
      pop_expect(4'd5);
      pop_expect(4'd7);

      // full with simultaneous pop: pop only, push next cycle
      for (int i = 1; i <= 4; i++) push_word(4'(i));
      up_valid = 1'b1; up_data = 4'd6; dn_ready = 1'b1;
      step();
      chk("fullpop_count", 32'(count), 32'd3);
      dn_ready = 1'b0;
      step();
      up_valid = 1'b0;
      chk("refill_count", 32'(count), 32'd4);

      // streaming at count 2
      dn_ready = 1'b1;
      step();
      step();
      for (int i = 0; i < 10; i++) begin
         up_valid = 1'b1; up_data = 4'(i); dn_ready = 1'b1;
         step();
         chk("stream_count", 32'(count), 32'd2);
      end
      up_valid = 1'b0;
      for (int i = 8; i < 10; i++) pop_expect(4'(i));

      // reset mid-operation
      push_word(4'd8);
      push_word(4'd12);
      push_word(4'd9);
      rst = 1'b0; dn_ready = 1'b1;
      step();
      dn_ready = 1'b0;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_valid", 32'(dn_valid), 32'd0);
      rst = 1'b1;
      push_word(4'd4);
      pop_expect(4'd4);

      // randomized traffic; a stalled up_valid keeps its word
      pending = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pending) begin
            up_valid = ($urandom_range(0, 3) != 0);
            up_data  = 4'($urandom);
         end
         dn_ready = ($urandom_range(0, 2) != 0);
         rst      = ($urandom_range(0, 59) != 0);
         pending  = up_valid && !(rst && q.size() < DEPTH);
         step();
      end
      rst = 1'b1; up_valid = 1'b0; dn_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) step();
      chk("final_empty", 32'(dn_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/handshake_fifo.md
# handshake_fifo

Valid/ready elastic buffer that sits directly downstream of the `handshake` stage. It absorbs words accepted on its upstream port and presents them in order on its downstream port, so short stalls on the consumer side do not stall the producer. It is a synchronous circular FIFO with occupancy tracking. Output data is first-word-fall-through and is forced to zero when the FIFO is empty.

## Interface
Parameters:
- `wd`, 4, data width in bits
- `depth`, 4, number of entries; must be a power of 2 and ≥ 2
- `aw`, 2, pointer width; must equal log2(`depth`)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous reset, active-low (`rst`=0 resets on next rising edge)
- `up_valid`  in  1  upstream word on `up_data` is valid
- `up_ready`  out  1  FIFO can accept a word this cycle
- `up_data`  in  `wd`  upstream data
- `dn_valid`  out  1  `dn_data` holds the oldest stored word
- `dn_ready`  in  1  downstream consumes `dn_data` this cycle
- `dn_data`  out  `wd`  head-of-FIFO data
- `count`  out  `aw`+1  current occupancy, 0..`depth`

## Operation
- Storage: `depth` × `wd` register array (not reset); `wr_ptr` and `rd_ptr` are `aw` bits and wrap naturally at `depth`; `count` is `aw`+1 bits.
- Push = `up_valid` & `up_ready`. It writes `up_data` to `mem[wr_ptr]` and increments `wr_ptr` modulo `depth`.
- Pop = `dn_valid` & `dn_ready`. It increments `rd_ptr` modulo `depth`.
- Count update: push only → +1; pop only → −1; both or neither → unchanged.
- `up_ready` = `rst` & (`count` != `depth`). It is 0 while reset is asserted and 0 when full.
- `dn_valid` = (`count` != 0).
- `dn_data` = `mem[rd_ptr]` when `count` != 0, else 0.
- Full: `up_ready`=0, so no push. A pop in the same cycle does not enable a push; there is no full-cycle pass-through. `up_ready` rises the cycle after the pop.
- Empty: `dn_valid`=0. There is no combinational bypass, so a push becomes visible on `dn_valid` the next cycle.
- Simultaneous push and pop at 0 < `count` < `depth`: both occur, `count` is unchanged, and the pointers advance together.
- Pop when `dn_valid`=0 and push when `up_ready`=0 are ignored. No state changes and no error flag.
- `up_data` is ignored when `up_valid`=0. `dn_ready` is ignored when `dn_valid`=0.
- Ordering: words leave in exactly the order they were accepted. No loss and no duplication.

## Timing
- Reset (`rst`=0 sampled at an edge): `wr_ptr`, `rd_ptr` and `count` go to 0. From that edge onward `dn_valid`=0, `dn_data`=0, `count`=0, and `up_ready`=0 until `rst` returns to 1.
- Reset mid-operation discards all stored words in one edge. A push or pop in the reset cycle is ignored.
- Latency: a word pushed at edge N appears on `dn_valid`/`dn_data` after edge N, provided it is at the head.
- Throughput: one push and one pop per cycle sustained when 0 < `count` < `depth`.
- `up_ready` depends only on `count` and `rst`, never on `dn_ready`. `dn_valid` and `dn_data` depend only on state. There is no combinational path from inputs to outputs except `rst` → `up_ready`.
- Handshake rules the producer and consumer must follow: once `up_valid` is asserted, `up_valid`/`up_data` hold until accepted. `dn_valid`/`dn_data` are stable until popped or reset.

## Test plan
(`wd`=4, `depth`=4)
- Reset: hold `rst`=0 for 2 edges with `up_valid`=1 → `count`=0, `dn_valid`=0, `dn_data`=0, `up_ready`=0. Release `rst` → `up_ready`=1 the same cycle.
- Single word: push 8 with `dn_ready`=0 → next cycle `dn_valid`=1, `dn_data`=8, `count`=1. Assert `dn_ready` → after the edge `dn_valid`=0, `dn_data`=0, `count`=0.
- Fill, wrap and order: push 8, 12, 9, 3 with `dn_ready`=0 → `count`=4, `up_ready`=0. Hold `up_valid`=1 with 5 → not accepted. Drain → 8, 12, 9, 3 in order. Then push 5, 7, which wrap the pointers → outputs 5, 7.
- Full with simultaneous pop: at `count`=4 assert `dn_ready`=1 and `up_valid`=1 (data 6) for one cycle → pop only, `count`=3. Next cycle `up_ready`=1 and 6 is accepted, giving `count`=4.
- Streaming: `count`=2, `up_valid`=`dn_ready`=1 for 10 cycles with an incrementing pattern → `count` stays 2 and the output sequence lags the input by 2 with no gaps.
- Reset mid-operation: `count`=3 holding 8, 12, 9, then `rst`=0 for 1 edge → `count`=0, `dn_valid`=0. After release, push 4 → the first word out is 4.
